n101_spigpioport_gen: RTL and testbench
=======================================

# n101_spigpioport_gen

Parametrised SPI-to-pad adapter for the n101 peripheral subsystem, sitting between an SPI/QSPI controller and the GPIO pad-control bundle. It drives SCK and NUM_CS chip selects to pads and handles NUM_DQ bidirectional data lanes. Each data lane has a SYNC_STAGES-deep input synchroniser and a per-lane direction-turnaround state machine, which keeps pad drivers from overlapping an external driver. Captured input is held while a lane is driving, so the controller never samples its own output.

## Interface
Parameters:
- NUM_DQ, 4: data lanes, legal 1..8.
- NUM_CS, 1: chip selects, legal 1..4.
- SYNC_STAGES, 3: input synchroniser depth, legal 2..4.
- TURN_CYCLES, 1: dead cycles between input and output direction, legal 0..7.

Ports:
- clock  in  1  Single clock; all state on its rising edge.
- reset  in  1  Reset is synchronous and active-high.
- io_spi_sck  in  1  Controller SCK.
- io_spi_dq_o  in  NUM_DQ  Controller output data.
- io_spi_dq_oe  in  NUM_DQ  Controller output-enable request per lane.
- io_spi_dq_i  out  NUM_DQ  Synchronised, held input data to controller.
- io_spi_cs  in  NUM_CS  Controller chip selects.
- io_pins_sck_i_ival  in  1  Unused.
- io_pins_sck_o_oval, _oe, _ie, _pue, _ds  out  1 each  SCK pad control.
- io_pins_dq_i_ival  in  NUM_DQ  Pad input values.
- io_pins_dq_o_oval, _oe, _ie, _pue, _ds  out  NUM_DQ each  DQ pad control.
- io_pins_cs_i_ival  in  NUM_CS  Unused.
- io_pins_cs_o_oval, _oe, _ie, _pue, _ds  out  NUM_CS each  CS pad control.
- io_turn_busy  out  1  OR of all lanes in the TURN state.

## Operation
SCK and CS pads:
- oval follows the SPI input combinationally.
- oe=1, ie=0, pue=0, ds=1, constant.

DQ pads, per lane:
- oval = io_spi_dq_o[n], combinational.
- pue=1, ds=1, constant.
- oe = (state==OUT).
- ie = (state==IN).

Lane FSM (states IN, TURN, OUT; reset state IN, turnaround counter cleared to 0):
- IN, spi_oe=1: go to TURN with cnt=TURN_CYCLES-1. If TURN_CYCLES==0, go straight to OUT.
- TURN, spi_oe=0: go to IN (request withdrawn; abort).
- TURN, spi_oe=1, cnt==0: go to OUT.
- TURN, spi_oe=1, cnt!=0: cnt decrements, stay in TURN.
- OUT, spi_oe=0: go to IN. The bus is released without a dead period.
- Any other case: hold state.

Input path, per lane:
- sync[0] <= pin.
- sync[k] <= sync[k-1].
- Hold register updates from sync[SYNC_STAGES-1] only while state==IN. In TURN and OUT it keeps its last value.
- io_spi_dq_i = hold register.

Reset:
- While reset is high, every FSM is forced to IN and counters, sync stages and hold registers clear to 0. Reset overrides any transition in the same cycle.
- State of each output after the first edge with reset high: dq_o_oe=0, dq_o_ie=1, io_spi_dq_i=0, io_turn_busy=0. CS/SCK outputs are combinational and unaffected by reset.
- Reset asserted mid-turnaround or mid-drive drops pad oe the cycle after that edge.

## Timing
- Pin to io_spi_dq_i: SYNC_STAGES+1 cycles, lane in IN.
- spi_oe rise to pad oe rise: TURN_CYCLES+1 cycles.
- During those cycles pad ie is 0 for TURN_CYCLES cycles.
- spi_oe fall to pad oe fall: 1 cycle. Pad ie rises in the same cycle.
- First sync-sourced hold update after returning to IN: on the edge ending that IN cycle.
- Re-capture latency after a drive phase:
  - sync stages keep tracking the pin during TURN/OUT, so no extra flush occurs.
  - Values that were on the pin during OUT can still appear; the controller discards the first SYNC_STAGES samples after turnaround.
- A spi_oe pulse shorter than TURN_CYCLES+1 cycles never asserts pad oe.
- Lanes are fully independent; simultaneous transitions on different lanes need no arbitration.

## Configuration
- N101_SPIGPIO_LOOPBACK_EN defined:
  - Adds input port io_loopback (1 bit).
  - When io_loopback=1, sync[0] samples io_spi_dq_o[n] instead of the pin.
  - The hold register updates every cycle regardless of FSM state.
  - Pad outputs are unchanged.
- Not defined:
  - The port is absent and the pin is the only input source.

## Test plan
- Reset sequence: reset high for 2 cycles with spi_oe=4'hF -> dq_o_oe=0, dq_o_ie=4'hF, io_spi_dq_i=0. After release, lane oe rises at cycle TURN_CYCLES+1.
- Input latency, SYNC_STAGES=3: pin lane0 0->1 at cycle 0, lanes idle -> io_spi_dq_i[0]=1 from cycle 4, not before.
- Turnaround, TURN_CYCLES=2:
  - spi_oe[1] rises at cycle 0 -> ie[1]=0 and io_turn_busy=1 for cycles 1-2; oe[1]=1 from cycle 3.
  - spi_oe[1] falls at cycle 10 -> oe[1]=0 and ie[1]=1 at cycle 11.
- Abort and hold: spi_oe[2] high for 1 cycle with TURN_CYCLES=2 -> oe[2] never 1, FSM back to IN. Pin toggling while lane 3 is in OUT -> io_spi_dq_i[3] constant.
- CS/SCK passthrough, NUM_CS=2: drive io_spi_cs=2'b10 and toggle sck -> cs oval=2'b10 same cycle, oe=2'b11, pue=0, ds=1.
- Loopback build: io_loopback=1, spi_dq_o=4'hA, spi_oe=4'hF -> io_spi_dq_i=4'hA after SYNC_STAGES+1 cycles, independent of pin values.

Source files
------------

// File: rtl/n101_spigpioport_gen.sv
// SPI/QSPI controller to GPIO pad adapter: SCK/CS pass-through, per-lane DQ
// direction turnaround FSM, input synchroniser and hold register.
// Optional build macro: N101_SPIGPIO_LOOPBACK_EN (adds io_loopback input).
module n101_spigpioport_gen #(
  parameter int unsigned NUM_DQ      = 4,
  parameter int unsigned NUM_CS      = 1,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_spi_sck,
  input  logic [NUM_DQ-1:0] io_spi_dq_o,
  input  logic [NUM_DQ-1:0] io_spi_dq_oe,
  output logic [NUM_DQ-1:0] io_spi_dq_i,
  input  logic [NUM_CS-1:0] io_spi_cs,
  input  logic              io_pins_sck_i_ival,
  output logic              io_pins_sck_o_oval,
  output logic              io_pins_sck_o_oe,
  output logic              io_pins_sck_o_ie,
  output logic              io_pins_sck_o_pue,
  output logic              io_pins_sck_o_ds,
  input  logic [NUM_DQ-1:0] io_pins_dq_i_ival,
  output logic [NUM_DQ-1:0] io_pins_dq_o_oval,
  output logic [NUM_DQ-1:0] io_pins_dq_o_oe,
  output logic [NUM_DQ-1:0] io_pins_dq_o_ie,
  output logic [NUM_DQ-1:0] io_pins_dq_o_pue,
  output logic [NUM_DQ-1:0] io_pins_dq_o_ds,
  input  logic [NUM_CS-1:0] io_pins_cs_i_ival,
  output logic [NUM_CS-1:0] io_pins_cs_o_oval,
  output logic [NUM_CS-1:0] io_pins_cs_o_oe,
  output logic [NUM_CS-1:0] io_pins_cs_o_ie,
  output logic [NUM_CS-1:0] io_pins_cs_o_pue,
  output logic [NUM_CS-1:0] io_pins_cs_o_ds,
`ifdef N101_SPIGPIO_LOOPBACK_EN
  input  logic              io_loopback,
`endif
  output logic              io_turn_busy
);

  typedef enum logic [1:0] {
    ST_IN   = 2'd0,
    ST_TURN = 2'd1,
    ST_OUT  = 2'd2
  } lane_state_e;

  localparam logic [2:0] LP_TURN_INIT = (TURN_CYCLES == 0) ? 3'd0 : 3'(TURN_CYCLES - 1);

  lane_state_e       r_state     [NUM_DQ];
  lane_state_e       w_state_nxt [NUM_DQ];
  logic [2:0]        r_cnt       [NUM_DQ];
  logic [2:0]        w_cnt_nxt   [NUM_DQ];
  logic [NUM_DQ-1:0] r_sync      [SYNC_STAGES];
  logic [NUM_DQ-1:0] r_hold;
  logic [NUM_DQ-1:0] w_sync_src;
  logic [NUM_DQ-1:0] w_hold_en;
  logic [NUM_DQ-1:0] w_lane_in;
  logic [NUM_DQ-1:0] w_lane_out;
  logic [NUM_DQ-1:0] w_lane_turn;
  logic              w_unused;

  assign w_unused = ^{io_pins_sck_i_ival, io_pins_cs_i_ival};

  // SCK / CS pads: always-driven outputs, no pull, strong drive
  assign io_pins_sck_o_oval = io_spi_sck;
  assign io_pins_sck_o_oe   = 1'b1;
  assign io_pins_sck_o_ie   = 1'b0;
  assign io_pins_sck_o_pue  = 1'b0;
  assign io_pins_sck_o_ds   = 1'b1;

  assign io_pins_cs_o_oval  = io_spi_cs;
  assign io_pins_cs_o_oe    = '1;
  assign io_pins_cs_o_ie    = '0;
  assign io_pins_cs_o_pue   = '0;
  assign io_pins_cs_o_ds    = '1;

  // Lane FSM: state register
  always_ff @(posedge clock) begin
    for (int unsigned n = 0; n < NUM_DQ; n++) begin
      if (reset) begin
        r_state[n] <= ST_IN;
        r_cnt[n]   <= '0;
      end else begin
        r_state[n] <= w_state_nxt[n];
        r_cnt[n]   <= w_cnt_nxt[n];
      end
    end
  end

  // Lane FSM: next-state logic
  always_comb begin
    for (int unsigned n = 0; n < NUM_DQ; n++) begin
      w_state_nxt[n] = r_state[n];
      w_cnt_nxt[n]   = r_cnt[n];
      unique case (r_state[n])
        ST_IN: begin
          if (io_spi_dq_oe[n]) begin
            if (TURN_CYCLES == 0) begin
              w_state_nxt[n] = ST_OUT;
            end else begin
              w_state_nxt[n] = ST_TURN;
              w_cnt_nxt[n]   = LP_TURN_INIT;
            end
          end
        end
        ST_TURN: begin
          if (!io_spi_dq_oe[n]) begin
            w_state_nxt[n] = ST_IN;
          end else if (r_cnt[n] == 3'd0) begin
            w_state_nxt[n] = ST_OUT;
          end else begin
            w_cnt_nxt[n] = r_cnt[n] - 3'd1;
          end
        end
        ST_OUT: begin
          if (!io_spi_dq_oe[n]) begin
            w_state_nxt[n] = ST_IN;
          end
        end
        default: begin
          w_state_nxt[n] = ST_IN;
        end
      endcase
    end
  end

  // Lane FSM: output decode
  always_comb begin
    w_lane_in   = '0;
    w_lane_out  = '0;
    w_lane_turn = '0;
    for (int unsigned n = 0; n < NUM_DQ; n++) begin
      w_lane_in[n]   = (r_state[n] == ST_IN);
      w_lane_out[n]  = (r_state[n] == ST_OUT);
      w_lane_turn[n] = (r_state[n] == ST_TURN);
    end
  end

  assign io_pins_dq_o_oval = io_spi_dq_o;
  assign io_pins_dq_o_oe   = w_lane_out;
  assign io_pins_dq_o_ie   = w_lane_in;
  assign io_pins_dq_o_pue  = '1;
  assign io_pins_dq_o_ds   = '1;
  assign io_turn_busy      = |w_lane_turn;

`ifdef N101_SPIGPIO_LOOPBACK_EN
  assign w_sync_src = io_loopback ? io_spi_dq_o : io_pins_dq_i_ival;
  assign w_hold_en  = io_loopback ? '1 : w_lane_in;
`else
  assign w_sync_src = io_pins_dq_i_ival;
  assign w_hold_en  = w_lane_in;
`endif

  // Synchroniser keeps tracking the pin in every state; only the hold register gates
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
      r_hold <= '0;
    end else begin
      r_sync[0] <= w_sync_src;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_hold <= (w_hold_en & r_sync[SYNC_STAGES-1]) | (~w_hold_en & r_hold);
    end
  end

  assign io_spi_dq_i = r_hold;

endmodule

// File: tb/tb_n101_spigpioport_gen.sv
// Scoreboard bench for n101_spigpioport_gen: a per-edge reference model pushes
// expected lane outputs; a negedge monitor pops and compares.
module tb_n101_spigpioport_gen;

  localparam int NQ = 4;
  localparam int NC = 2;
  localparam int S  = 3;
  localparam int T  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          io_spi_sck = 1'b0;
  logic [NQ-1:0] io_spi_dq_o = '0;
  logic [NQ-1:0] io_spi_dq_oe = '1;
  logic [NQ-1:0] io_spi_dq_i;
  logic [NC-1:0] io_spi_cs = '0;
  logic          io_pins_sck_i_ival = 1'b0;
  logic          sck_oval, sck_oe, sck_ie, sck_pue, sck_ds;
  logic [NQ-1:0] io_pins_dq_i_ival = '0;
  logic [NQ-1:0] dq_oval, dq_oe, dq_ie, dq_pue, dq_ds;
  logic [NC-1:0] io_pins_cs_i_ival = '0;
  logic [NC-1:0] cs_oval, cs_oe, cs_ie, cs_pue, cs_ds;
  logic          io_turn_busy;

  int total = 0;
  int bad   = 0;

  n101_spigpioport_gen #(
    .NUM_DQ(NQ), .NUM_CS(NC), .SYNC_STAGES(S), .TURN_CYCLES(T)
  ) dut (
    .clock(clock), .reset(reset),
    .io_spi_sck(io_spi_sck), .io_spi_dq_o(io_spi_dq_o), .io_spi_dq_oe(io_spi_dq_oe),
    .io_spi_dq_i(io_spi_dq_i), .io_spi_cs(io_spi_cs),
    .io_pins_sck_i_ival(io_pins_sck_i_ival),
    .io_pins_sck_o_oval(sck_oval), .io_pins_sck_o_oe(sck_oe), .io_pins_sck_o_ie(sck_ie),
    .io_pins_sck_o_pue(sck_pue), .io_pins_sck_o_ds(sck_ds),
    .io_pins_dq_i_ival(io_pins_dq_i_ival),
    .io_pins_dq_o_oval(dq_oval), .io_pins_dq_o_oe(dq_oe), .io_pins_dq_o_ie(dq_ie),
    .io_pins_dq_o_pue(dq_pue), .io_pins_dq_o_ds(dq_ds),
    .io_pins_cs_i_ival(io_pins_cs_i_ival),
    .io_pins_cs_o_oval(cs_oval), .io_pins_cs_o_oe(cs_oe), .io_pins_cs_o_ie(cs_ie),
    .io_pins_cs_o_pue(cs_pue), .io_pins_cs_o_ds(cs_ds),
    .io_turn_busy(io_turn_busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NQ-1:0] oe;
    logic [NQ-1:0] ie;
    logic [NQ-1:0] dqi;
    logic          busy;
  } exp_t;

  exp_t          scb[$];
  logic [NQ-1:0] pinq[$];   // pin history, newest at front; reset flushes to zeros
  int            run[NQ];   // consecutive edges with oe requested and no reset
  logic [NQ-1:0] m_hold = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a lane drives once oe has been requested for T+1 edges,
  // is in turnaround for 1..T edges, and captures the pin S+1 edges late while receiving.
  always @(posedge clock) begin
    exp_t          e;
    logic [NQ-1:0] so;
    if (reset) begin
      for (int n = 0; n < NQ; n++) run[n] = 0;
      pinq.delete();
      for (int k = 0; k < S; k++) pinq.push_front('0);
      m_hold = '0;
    end else begin
      so = pinq[S-1];
      for (int n = 0; n < NQ; n++) begin
        if (run[n] == 0) m_hold[n] = so[n];
        if (!io_spi_dq_oe[n]) run[n] = 0;
        else if (run[n] < T + 1) run[n] = run[n] + 1;
      end
      pinq.push_front(io_pins_dq_i_ival);
      void'(pinq.pop_back());
    end
    e.busy = 1'b0;
    for (int n = 0; n < NQ; n++) begin
      e.oe[n] = (run[n] >= T + 1);
      e.ie[n] = (run[n] == 0);
      if (run[n] >= 1 && run[n] <= T) e.busy = 1'b1;
    end
    e.dqi = m_hold;
    scb.push_back(e);
  end

  // Monitor: combinational pad paths every negedge, registered paths from the scoreboard
  always @(negedge clock) begin
    exp_t e;
    chk("sck_oval", 32'(sck_oval), 32'(io_spi_sck));
    chk("sck_ctl", {27'd0, sck_oe, sck_ie, sck_pue, sck_ds}, 32'b1001);
    chk("cs_oval", 32'(cs_oval), 32'(io_spi_cs));
    chk("cs_ctl", {cs_oe, cs_ie, cs_pue, cs_ds}, {2'b11, 2'b00, 2'b00, 2'b11});
    chk("dq_oval", 32'(dq_oval), 32'(io_spi_dq_o));
    chk("dq_pue_ds", {dq_pue, dq_ds}, {NQ{2'b11}});
    if (scb.size() > 0) begin
      e = scb.pop_front();
      chk("dq_oe", 32'(dq_oe), 32'(e.oe));
      chk("dq_ie", 32'(dq_ie), 32'(e.ie));
      chk("spi_dq_i", 32'(io_spi_dq_i), 32'(e.dqi));
      chk("turn_busy", 32'(io_turn_busy), 32'(e.busy));
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  initial begin
    // reset with every lane requesting output
    step(); step();
    reset = 1'b0;
    repeat (5) step();
    io_spi_dq_oe = '0;
    repeat (3) step();
    // input latency on lane 0
    io_pins_dq_i_ival = 4'b0001;
    repeat (6) step();
    // turnaround on lane 1, then release
    io_spi_dq_oe[1] = 1'b1;
    repeat (10) step();
    io_spi_dq_oe[1] = 1'b0;
    repeat (3) step();
    // one-cycle abort on lane 2
    io_spi_dq_oe[2] = 1'b1;
    step();
    io_spi_dq_oe[2] = 1'b0;
    repeat (3) step();
    // lane 3 driving while its pin toggles
    io_spi_dq_oe[3] = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      io_pins_dq_i_ival[3] = ~io_pins_dq_i_ival[3];
      step();
    end
    io_spi_dq_oe[3] = 1'b0;
    repeat (6) step();
    // CS / SCK pass-through
    io_spi_cs = 2'b10;
    for (int i = 0; i < 4; i++) begin
      io_spi_sck = ~io_spi_sck;
      step();
    end
    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < NQ; n++) begin
        if ($urandom_range(5, 0) == 0) io_spi_dq_oe[n] = ~io_spi_dq_oe[n];
      end
      io_pins_dq_i_ival = NQ'($urandom);
      io_spi_dq_o       = NQ'($urandom);
      io_spi_cs         = NC'($urandom);
      io_spi_sck        = 1'($urandom);
      reset             = ($urandom_range(99, 0) == 0);
      step();
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
